// File: rtl/pbit_sample_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pbit_sample_decoder_pkg
//  Purpose  : Shared p-bit definitions: field widths of the 6-bit p-bit input
//             word {A[3:0], BS[1:0]}, bias-shift encodings, decoder state
//             encodings and a small helper describing p-bit firing.
//  Revision : 1.0 - initial release
// ============================================================================
package pbit_sample_decoder_pkg;

    localparam int PBIT_IN_W  = 6;   // full p-bit input word {A, BS}
    localparam int PBIT_A_W   = 4;   // activation field
    localparam int PBIT_BS_W  = 2;   // bias-shift field
    localparam int PBIT_RNG_W = 5;   // p-bit internal random number width

    typedef logic [PBIT_A_W-1:0]   pbit_a_t;
    typedef logic [PBIT_RNG_W-1:0] pbit_rng_t;
    typedef logic [PBIT_IN_W-1:0]  pbit_code_t;

    typedef enum logic [PBIT_BS_W-1:0] {
        BS_NONE = 2'b00,
        BS_SHR1 = 2'b01,
        BS_SHL1 = 2'b10,
        BS_SHL2 = 2'b11
    } pbit_bs_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // A p-bit with activation a emits a 1 when a < rng (rng is 1..31), so
    // the fraction of zeros over many samples tracks a/31.
    function automatic logic pbit_fires(input pbit_a_t a, input pbit_rng_t rng);
        return {1'b0, a} < rng;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pbit_sample_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : pbit_sample_decoder
//  Purpose  : Counts ones in a window of 2**WIN_LOG2 p-bit samples and
//             re-encodes the zero fraction as a 6-bit p-bit input word
//             {A[3:0], 2'b00}, with a valid/ready result handshake.
//  Ports    : clk          - clock, rising edge
//             reset_n      - asynchronous active-low reset
//             start        - begin a window (IDLE, or HOLD with ready)
//             abort        - drop current window, return to IDLE
//             pbit_in      - p-bit stream, sampled each ACCUM cycle
//             busy         - window accumulation in progress
//             sample_valid - result held for the consumer
//             sample_ready - consumer accepts the result
//             ones_count   - ones in the last completed window (0..N)
//             sample_code  - {A, BS} estimate, BS always 2'b00
//  Revision : 1.0 - initial release
// ============================================================================
module pbit_sample_decoder
    import pbit_sample_decoder_pkg::*;
#(
    parameter int WIN_LOG2 = 5,
    parameter int CNT_W    = WIN_LOG2 + 1
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pbit_in,
    output logic             busy,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [CNT_W-1:0] ones_count,
    output pbit_code_t       sample_code
);

    localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(2 ** WIN_LOG2);

    logic [1:0]          state;
    logic [CNT_W-1:0]    acc;
    logic [WIN_LOG2-1:0] idx;
    logic [CNT_W-1:0]    acc_next;
    logic [CNT_W-1:0]    zeros_next;

    // Normalise the zero count to a 32-sample window, then saturate to the
    // 4-bit activation range.
    function automatic pbit_code_t pbit_encode_zeros(input logic [CNT_W-1:0] zeros);
        logic [CNT_W-1:0] z5;
        pbit_a_t          a;
        z5 = zeros >> (WIN_LOG2 - 5);
        if (z5 > CNT_W'(15)) begin
            a = 4'hF;
        end else begin
            a = z5[PBIT_A_W-1:0];
        end
        return {a, BS_NONE};
    endfunction

    // The count including the current sample; acc never exceeds WIN_LEN,
    // which fits in CNT_W bits.
    always_comb begin
        acc_next   = acc + CNT_W'(pbit_in);
        zeros_next = WIN_LEN - acc_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            idx         <= '0;
            ones_count  <= '0;
            sample_code <= '0;
        end else if (abort) begin
            // Results stay as they were; the window in flight is discarded.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ACCUM;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + WIN_LOG2'(1);
                    // idx all-ones marks the final sample of the window.
                    if (&idx) begin
                        ones_count  <= acc_next;
                        sample_code <= pbit_encode_zeros(zeros_next);
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (sample_ready) begin
                        if (start) begin
                            // Back-to-back window with no idle bubble.
                            state <= ST_ACCUM;
                            acc   <= '0;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state == ST_ACCUM);
    assign sample_valid = (state == ST_HOLD);

endmodule
`default_nettype wire
